bp_btb: RTL and testbench

BP_BTB -- requirements
Module: bp_btb

---
 rtl/pipes_pkg.sv | 50 +++++
 rtl/bp_counter_sat.sv | 32 +++
 rtl/bp_btb.sv | 154 +++++++++++++++
 tb/tb_bp_btb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipes_pkg.sv
// Shared pipeline types for the branch predictor.
// BP_2BIT_COUNTER_EN selects 2-bit saturating direction counters instead of a
// 1-bit last-outcome bit.
package pipes;

  localparam int unsigned XLEN = 64;

  typedef logic [XLEN-1:0] addr_t;

  typedef enum logic [1:0] {
    PCPLUS4 = 2'd0,
    PCJUMP  = 2'd1
  } pcsrc_t;

  // Resolved control-flow outcome from the execute stage.
  typedef struct packed {
    addr_t  pc;
    addr_t  target_pc;
    pcsrc_t pcsrc;
  } bp_result_t;

`ifdef BP_2BIT_COUNTER_EN
  localparam int unsigned BP_CNT_W = 2;
`else
  localparam int unsigned BP_CNT_W = 1;
`endif

  typedef logic [BP_CNT_W-1:0] bp_cnt_t;

  // Weakly taken for 2-bit counters, taken for the 1-bit scheme.
  localparam bp_cnt_t BP_CNT_ALLOC = bp_cnt_t'(1 << (BP_CNT_W - 1));

  // With at least two sets the index eats pc[2], so the tag never exceeds
  // XLEN-3 bits; narrower tags are stored zero-extended.
  localparam int unsigned BP_TAG_W = XLEN - 3;

  typedef logic [BP_TAG_W-1:0] bp_tag_t;

  typedef struct packed {
    logic    valid;
    bp_tag_t tag;
    addr_t   target;
    bp_cnt_t cnt;
  } bp_entry_t;

  function automatic logic bp_cnt_taken(bp_cnt_t c);
    return c[BP_CNT_W-1];
  endfunction

endpackage

// File: rtl/bp_counter_sat.sv
// Next-state function of one BTB direction counter.
// BP_2BIT_COUNTER_EN: 2-bit saturating up/down counter; otherwise the counter
// simply records the latest outcome.
module bp_counter_sat
  import pipes::*;
(
  input  bp_cnt_t cnt_i,
  input  logic    taken_i,
  output bp_cnt_t cnt_o
);

`ifdef BP_2BIT_COUNTER_EN
  // Saturating increment on taken, decrement on not taken.
  always_comb begin
    cnt_o = cnt_i;
    if (taken_i) begin
      if (cnt_i != '1) cnt_o = cnt_i + 1'b1;
    end else begin
      if (cnt_i != '0) cnt_o = cnt_i - 1'b1;
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt = ^cnt_i;

  // Last-outcome bit: the new value is the outcome itself.
  always_comb begin
    cnt_o = taken_i;
  end
`endif

endmodule

// File: rtl/bp_btb.sv
// 2-way set-associative branch target buffer with per-set LRU.
// Lookup is purely combinational from the registered table; updates and
// invalidation commit on the rising clock edge.
// BP_2BIT_COUNTER_EN selects the direction counter width (see bp_counter_sat).
module bp_btb
  import pipes::*;
#(
  parameter int unsigned SETS = 16  // power of two, >= 2
) (
  input  logic       clk,
  input  logic       reset,
  input  addr_t      lk_pc,
  output pcsrc_t     pred_pcsrc,
  output addr_t      pred_target,
  output logic       pred_hit,
  input  logic       upd_valid,
  input  bp_result_t upd,
  input  logic       inv
);

  localparam int unsigned IW = $clog2(SETS);

  typedef logic [IW-1:0] idx_t;

  function automatic idx_t pc_idx(addr_t pc);
    return pc[IW+1:2];
  endfunction

  function automatic bp_tag_t pc_tag(addr_t pc);
    return bp_tag_t'(pc >> (IW + 2));
  endfunction

  bp_entry_t       tbl_q [SETS][2];
  logic [SETS-1:0] lru_q;  // per set: way to evict next

  // Instruction-aligned PCs: the two low bits never select anything.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{lk_pc[1:0], upd.pc[1:0]};

  // ---------------------------------------------------------------------------
  // Lookup
  // ---------------------------------------------------------------------------
  idx_t      lk_idx;
  bp_tag_t   lk_tag;
  logic [1:0] lk_hit;
  logic      lk_way;
  bp_entry_t lk_ent;

  // Tag match in both ways of the looked-up set; at most one can match.
  always_comb begin
    lk_idx = pc_idx(lk_pc);
    lk_tag = pc_tag(lk_pc);
    for (int w = 0; w < 2; w++) begin
      lk_hit[w] = tbl_q[lk_idx][w].valid && (tbl_q[lk_idx][w].tag == lk_tag);
    end
    lk_way = lk_hit[0] ? 1'b0 : 1'b1;
    lk_ent = tbl_q[lk_idx][lk_way];
  end

  // Prediction outputs, forced idle while reset is held.
  always_comb begin
    pred_hit    = (|lk_hit) && !reset;
    pred_target = pred_hit ? lk_ent.target : '0;
    pred_pcsrc  = (pred_hit && bp_cnt_taken(lk_ent.cnt)) ? PCJUMP : PCPLUS4;
  end

  // ---------------------------------------------------------------------------
  // Update decode
  // ---------------------------------------------------------------------------
  idx_t       up_idx;
  bp_tag_t    up_tag;
  logic       up_taken;
  logic [1:0] up_hit;
  logic       up_hit_way;
  bp_cnt_t    up_cnt;
  bp_cnt_t    up_cnt_nxt;

  // Locate the resolved branch in its set and fetch its current counter.
  always_comb begin
    up_idx   = pc_idx(upd.pc);
    up_tag   = pc_tag(upd.pc);
    up_taken = (upd.pcsrc == PCJUMP);
    for (int w = 0; w < 2; w++) begin
      up_hit[w] = tbl_q[up_idx][w].valid && (tbl_q[up_idx][w].tag == up_tag);
    end
    up_hit_way = up_hit[0] ? 1'b0 : 1'b1;
    up_cnt     = tbl_q[up_idx][up_hit_way].cnt;
  end

  bp_counter_sat u_counter (
    .cnt_i   (up_cnt),
    .taken_i (up_taken),
    .cnt_o   (up_cnt_nxt)
  );

  logic      wr_en;
  logic      wr_way;
  bp_entry_t wr_ent;

  // Choose the way to write and its new contents: train on a hit, allocate on
  // a taken miss, ignore a not-taken miss.
  always_comb begin
    wr_en  = 1'b0;
    wr_way = 1'b0;
    wr_ent = '0;
    if (upd_valid) begin
      if (|up_hit) begin
        wr_en      = 1'b1;
        wr_way     = up_hit_way;
        wr_ent     = tbl_q[up_idx][up_hit_way];
        wr_ent.cnt = up_cnt_nxt;
        if (up_taken) wr_ent.target = upd.target_pc;
      end else if (up_taken) begin
        wr_en = 1'b1;
        if (!tbl_q[up_idx][0].valid) begin
          wr_way = 1'b0;
        end else if (!tbl_q[up_idx][1].valid) begin
          wr_way = 1'b1;
        end else begin
          wr_way = lru_q[up_idx];
        end
        wr_ent.valid  = 1'b1;
        wr_ent.tag    = up_tag;
        wr_ent.target = upd.target_pc;
        wr_ent.cnt    = BP_CNT_ALLOC;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Table state
  // ---------------------------------------------------------------------------
  // Invalidate wins over a coincident update; it leaves payload and LRU alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < 2; w++) begin
          tbl_q[s][w] <= '0;
        end
      end
      lru_q <= '0;
    end else if (inv) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < 2; w++) begin
          tbl_q[s][w].valid <= 1'b0;
        end
      end
    end else if (wr_en) begin
      tbl_q[up_idx][wr_way] <= wr_ent;
      lru_q[up_idx]         <= ~wr_way;
    end
  end

endmodule

// File: tb/tb_bp_btb.sv
// Self-checking bench for bp_btb: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// table-level behavioural model.
module tb_bp_btb;
  import pipes::*;

  localparam int unsigned SETS = 16;
  localparam int          IW   = $clog2(SETS);
`ifdef BP_2BIT_COUNTER_EN
  localparam int CMAX = 3;
  localparam int CNT_NT1 = 1;  // alloc 2, one not-taken
  localparam int CNT_TT  = 3;  // then two taken
`else
  localparam int CMAX = 1;
  localparam int CNT_NT1 = 0;
  localparam int CNT_TT  = 1;
`endif

  logic       clk;
  logic       reset;
  addr_t      lk_pc;
  pcsrc_t     pred_pcsrc;
  addr_t      pred_target;
  logic       pred_hit;
  logic       upd_valid;
  bp_result_t upd;
  logic       inv;

  bp_btb #(.SETS(SETS)) dut (
    .clk         (clk),
    .reset       (reset),
    .lk_pc       (lk_pc),
    .pred_pcsrc  (pred_pcsrc),
    .pred_target (pred_target),
    .pred_hit    (pred_hit),
    .upd_valid   (upd_valid),
    .upd         (upd),
    .inv         (inv)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: plain arrays of (valid, full tag, target, counter).
  bit              m_v   [SETS][2];
  longint unsigned m_tag [SETS][2];
  longint unsigned m_tgt [SETS][2];
  int              m_cnt [SETS][2];
  int              m_lru [SETS];

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  function automatic void m_clear();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < 2; w++) begin
        m_v[s][w] = 0; m_tag[s][w] = 0; m_tgt[s][w] = 0; m_cnt[s][w] = 0;
      end
      m_lru[s] = 0;
    end
  endfunction

  function automatic int m_set(longint unsigned pc);
    return int'((pc >> 2) % SETS);
  endfunction

  function automatic longint unsigned m_tagof(longint unsigned pc);
    return pc >> (IW + 2);
  endfunction

  function automatic int m_find(longint unsigned pc);
    int s = m_set(pc);
    for (int w = 0; w < 2; w++)
      if (m_v[s][w] && m_tag[s][w] == m_tagof(pc)) return w;
    return -1;
  endfunction

  function automatic void m_commit(bit uv, longint unsigned pc, longint unsigned tgt,
                                   bit taken, bit iv);
    int s, w;
    if (iv) begin
      for (int i = 0; i < SETS; i++) begin
        m_v[i][0] = 0; m_v[i][1] = 0;
      end
      return;
    end
    if (!uv) return;
    s = m_set(pc);
    w = m_find(pc);
    if (w >= 0) begin
      if (CMAX == 1) m_cnt[s][w] = taken ? 1 : 0;
      else if (taken) m_cnt[s][w] = (m_cnt[s][w] < CMAX) ? m_cnt[s][w] + 1 : CMAX;
      else m_cnt[s][w] = (m_cnt[s][w] > 0) ? m_cnt[s][w] - 1 : 0;
      if (taken) m_tgt[s][w] = tgt;
      m_lru[s] = 1 - w;
    end else if (taken) begin
      if (!m_v[s][0]) w = 0;
      else if (!m_v[s][1]) w = 1;
      else w = m_lru[s];
      m_v[s][w] = 1; m_tag[s][w] = m_tagof(pc); m_tgt[s][w] = tgt;
      m_cnt[s][w] = (CMAX + 1) / 2;
      m_lru[s] = 1 - w;
    end
  endfunction

  function automatic void m_predict(longint unsigned pc, output bit hit, output bit jump,
                                    output longint unsigned tgt);
    int w = m_find(pc);
    int s = m_set(pc);
    hit = (w >= 0);
    jump = hit && (m_cnt[s][w] * 2 > CMAX);
    tgt = hit ? m_tgt[s][w] : 64'd0;
  endfunction

  task automatic expect_out(string nm, bit hit, bit jump, longint unsigned tgt);
    bit got_jump;
    got_jump = (pred_pcsrc == PCJUMP);
    n_checks++;
    if (pred_hit !== hit || got_jump !== jump || pred_target !== tgt) begin
      n_fail++;
      $display("FAIL %s pc=%h: got hit=%0b jump=%0b target=%h, expected hit=%0b jump=%0b target=%h",
               nm, lk_pc, pred_hit, got_jump, pred_target, hit, jump, tgt);
    end
  endtask

  task automatic check_int(string nm, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    bit hit, jump;
    longint unsigned tgt;
    if (chk_en && !reset) begin
      m_predict(lk_pc, hit, jump, tgt);
      expect_out("cycle_lookup", hit, jump, tgt);
    end
  end

  // Drive one cycle of inputs; the model commits at the same edge as the DUT.
  task automatic step(longint unsigned lk, bit uv, longint unsigned upc,
                      longint unsigned utgt, bit taken, bit iv);
    lk_pc = lk; upd_valid = uv; inv = iv;
    upd.pc = upc; upd.target_pc = utgt; upd.pcsrc = taken ? PCJUMP : PCPLUS4;
    @(posedge clk);
    if (!reset) m_commit(uv, upc, utgt, taken, iv);
    #1;
    upd_valid = 1'b0; inv = 1'b0;
  endtask

  // Literal lookup check; at most three per group so it stays before negedge.
  task automatic look(string nm, longint unsigned pc, bit hit, bit jump,
                      longint unsigned tgt);
    lk_pc = pc; upd_valid = 1'b0; inv = 1'b0;
    #1;
    expect_out(nm, hit, jump, tgt);
  endtask

  localparam longint unsigned PA = 64'h8000_0010;
  localparam longint unsigned PB = 64'h8000_0050;
  localparam longint unsigned PC = 64'h8000_0090;
  localparam longint unsigned TA = 64'h8000_0100;
  localparam longint unsigned TB = 64'h8000_0500;
  localparam longint unsigned TC = 64'h8000_0900;

  initial begin
    reset = 1'b1; lk_pc = PA; upd_valid = 1'b0; inv = 1'b0; upd = '0;
    m_clear();
    #2;
    expect_out("reset_outputs", 0, 0, 64'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    chk_en = 1;

    // Cold miss, allocation, next-cycle hit.
    look("cold_miss", PA, 0, 0, 64'd0);
    step(PA, 1, PA, TA, 1, 0);
    look("alloc_hit", PA, 1, 1, TA);

    // Counter hysteresis.
    step(PA, 1, PA, 64'd0, 0, 0);
    look("nt_once", PA, 1, 0, TA);
    check_int("cnt_nt_once", m_cnt[4][0], CNT_NT1);
    step(PA, 1, PA, TA, 1, 0);
    step(PA, 1, PA, TA, 1, 0);
    look("taken_twice", PA, 1, 1, TA);
    check_int("cnt_taken_twice", m_cnt[4][0], CNT_TT);
    step(PA, 1, PA, 64'd0, 0, 0);
    step(PA, 1, PA, 64'd0, 0, 0);
    step(PA, 1, PA, 64'd0, 0, 0);
    look("nt_thrice", PA, 1, 0, TA);
    check_int("cnt_nt_thrice", m_cnt[4][0], 0);

    // Conflict and LRU replacement in set 4.
    step(PA, 0, 64'd0, 64'd0, 0, 1);
    look("inv_clears", PA, 0, 0, 64'd0);
    step(PA, 1, PA, TA, 1, 0);
    step(PB, 1, PB, TB, 1, 0);
    step(PA, 1, PA, TA, 1, 0);
    step(PC, 1, PC, TC, 1, 0);
    look("lru_evicted", PB, 0, 0, 64'd0);
    look("lru_kept", PA, 1, 1, TA);
    look("lru_new", PC, 1, 1, TC);

    // Not-taken miss never allocates.
    step(64'h8000_0020, 1, 64'h8000_0020, 64'h8000_0200, 0, 0);
    look("nt_miss", 64'h8000_0020, 0, 0, 64'd0);

    // Invalidate beats a same-cycle update.
    step(64'h8000_0030, 1, 64'h8000_0030, 64'h8000_0300, 1, 1);
    look("inv_a", PA, 0, 0, 64'd0);
    look("inv_c", PC, 0, 0, 64'd0);
    look("inv_upd", 64'h8000_0030, 0, 0, 64'd0);

    // Asynchronous reset between edges.
    step(PA, 1, PA, TA, 1, 0);
    look("pre_reset", PA, 1, 1, TA);
    reset = 1'b1;
    look("async_reset", PA, 0, 0, 64'd0);
    m_clear();
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk); #1;
    look("post_reset_a", PA, 0, 0, 64'd0);
    look("post_reset_c", PC, 0, 0, 64'd0);

    // Randomized traffic over a small aliasing pool of PCs.
    for (int i = 0; i < 3000; i++) begin
      longint unsigned upc, lk, tgt;
      bit uv, tk, iv;
      upc = 64'h8000_0000 | (longint'($urandom_range(0, 3)) << 6)
                          | (longint'($urandom_range(0, 3)) << 2);
      if ($urandom_range(0, 3) == 0) upc = upc | (64'd1 << 63);
      lk = ($urandom_range(0, 1) == 1) ? upc
         : (64'h8000_0000 | (longint'($urandom_range(0, 3)) << 6)
                          | (longint'($urandom_range(0, 3)) << 2));
      tgt = {32'h0, $urandom} & ~64'h3;
      uv = ($urandom_range(0, 1) == 1);
      tk = ($urandom_range(0, 2) != 0);
      iv = ($urandom_range(0, 63) == 0);
      step(lk, uv, upc, tgt, tk, iv);
    end

    @(negedge clk);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
